// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus controller.
// Optional feature macro: MEM_BUS_RDBUF_EN adds the one-entry read buffer and the HIT state.
package mem_bus_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WAIT_STATES = 2;
    localparam int WAIT_CNT_W      = 3;
    localparam int MAX_WAIT_STATES = 7;

    // Controller states; HIT only exists when the read buffer is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1
`ifdef MEM_BUS_RDBUF_EN
        ,
        ST_HIT    = 2'd2
`endif
    } mem_bus_state_t;

    // Kind of the transaction currently in flight.
    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_kind_t;

endpackage

// File: rtl/mem_bus_if.sv
// Request/response bus between the CPU control FSM and the memory bus controller.
// Optional feature macro: MEM_BUS_RDBUF_EN (no effect on this interface).
//
// Handshake: the master raises req_rd or req_wr with req_addr/req_wdata and holds
// them until it sees bus_ready high; the request is taken on the first rising edge
// where the controller is idle. bus_ready drops after that edge and rises again
// when the transaction is complete, at which point rdata holds the last read result.
// Requests presented while bus_ready is low are ignored, never queued.
interface mem_bus_if #(
    parameter int ADDR_W = mem_bus_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DEF_DATA_W
);
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              bus_ready;
    logic [DATA_W-1:0] rdata;
    logic              bus_err;

    modport master (
        output req_rd, req_wr, req_addr, req_wdata,
        input  bus_ready, rdata, bus_err
    );

    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata,
        output bus_ready, rdata, bus_err
    );
endinterface

// File: rtl/mem_bus_rdbuf.sv
// One-entry read buffer: remembers address/data of the last completed read.
// Instantiated by mem_bus_ctrl only when MEM_BUS_RDBUF_EN is defined.
module mem_bus_rdbuf #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_cycle,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inval_en,
    input  logic [ADDR_W-1:0] inval_addr
);
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    assign hit      = valid_q && (addr_q == lookup_addr);
    assign hit_data = data_q;

    // Fill on a completed read; drop the entry when a write targets the same address.
    always_ff @(posedge clk) begin
        if (reset_cycle) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr;
            data_q  <= fill_data;
        end else if (inval_en && (inval_addr == addr_q)) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: single outstanding read/write, fixed RAM wait states,
// registered RAM strobes and read data.
// Optional feature macro: MEM_BUS_RDBUF_EN compiles in a one-entry read buffer.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clk,
    input  logic              reset_cycle,
    mem_bus_if.slave          bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output mem_bus_state_t    state_dbg
);
    // The wait counter is 3 bits wide, so larger values cannot be represented.
    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_wait_range_check
        $error("mem_bus_ctrl: WAIT_STATES must be within 0..7");
    end

    mem_bus_state_t        state_q;
    mem_bus_state_t        state_d;
    req_kind_t             kind_q;
    req_kind_t             kind_d;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic                  accept;
    logic                  last_access;
    logic                  bus_ready_d;
    logic                  ram_re_d;
    logic                  ram_we_d;

    // A request is only looked at while idle; a write wins over a simultaneous read.
    assign accept      = (state_q == ST_IDLE) && (bus.req_rd || bus.req_wr);
    assign last_access = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign kind_d      = accept ? (bus.req_wr ? REQ_WR : REQ_RD) : kind_q;
    assign state_dbg   = state_q;

`ifdef MEM_BUS_RDBUF_EN
    logic              rd_hit;
    logic [DATA_W-1:0] hit_data;

    mem_bus_rdbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rdbuf (
        .clk         (clk),
        .reset_cycle (reset_cycle),
        .lookup_addr (bus.req_addr),
        .hit         (rd_hit),
        .hit_data    (hit_data),
        .fill_en     (last_access && (kind_q == REQ_RD)),
        .fill_addr   (ram_addr),
        .fill_data   (ram_rdata),
        .inval_en    (accept && bus.req_wr),
        .inval_addr  (bus.req_addr)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset_cycle) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> ACCESS (or HIT on a buffered read), back to IDLE when done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef MEM_BUS_RDBUF_EN
                    if (!bus.req_wr && rd_hit) state_d = ST_HIT;
                    else
`endif
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) state_d = ST_IDLE;
            end
`ifdef MEM_BUS_RDBUF_EN
            ST_HIT: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered ready level and RAM strobes.
    always_comb begin
        bus_ready_d = (state_d == ST_IDLE);
        ram_re_d    = (state_d == ST_ACCESS) && (kind_d == REQ_RD);
        ram_we_d    = (state_d == ST_ACCESS) && (kind_d == REQ_WR);
    end

    // Datapath registers: request latch, wait counter, read data, error flag.
    always_ff @(posedge clk) begin
        if (reset_cycle) begin
            bus.bus_ready <= 1'b1;
            bus.rdata     <= '0;
            bus.bus_err   <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_re        <= 1'b0;
            ram_we        <= 1'b0;
            kind_q        <= REQ_RD;
            cnt_q         <= '0;
        end else begin
            bus.bus_ready <= bus_ready_d;
            ram_re        <= ram_re_d;
            ram_we        <= ram_we_d;
            kind_q        <= kind_d;
            if (accept) begin
                ram_addr    <= bus.req_addr;
                ram_wdata   <= bus.req_wdata;
                cnt_q       <= WAIT_CNT_W'(WAIT_STATES);
                bus.bus_err <= bus.req_rd && bus.req_wr;
            end else if ((state_q == ST_ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - WAIT_CNT_W'(1);
            end
            if (last_access && (kind_q == REQ_RD)) begin
                bus.rdata <= ram_rdata;
            end
`ifdef MEM_BUS_RDBUF_EN
            if (state_q == ST_HIT) begin
                bus.rdata <= hit_data;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (2 wait states and 0 wait states) share
// one RAM model; a transaction-level reference model predicts latency, strobe
// counts, read data, error flag and read-buffer behaviour.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int WS_A = 2;
    localparam int WS_Z = 0;
`ifdef MEM_BUS_RDBUF_EN
    localparam bit RDBUF_EN = 1'b1;
`else
    localparam bit RDBUF_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_cycle;
    always #5 clk = ~clk;

    mem_bus_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
    mem_bus_if #(.ADDR_W(8), .DATA_W(8)) bus_z ();

    logic [7:0]     ram_addr_a, ram_wdata_a, ram_rdata_a;
    logic [7:0]     ram_addr_z, ram_wdata_z, ram_rdata_z;
    logic           ram_re_a, ram_we_a, ram_re_z, ram_we_z;
    mem_bus_state_t state_a, state_z;

    mem_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .reset_cycle(reset_cycle), .bus(bus_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_re(ram_re_a),
        .ram_we(ram_we_a), .ram_rdata(ram_rdata_a), .state_dbg(state_a)
    );

    mem_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS_Z)) u_dut_z (
        .clk(clk), .reset_cycle(reset_cycle), .bus(bus_z),
        .ram_addr(ram_addr_z), .ram_wdata(ram_wdata_z), .ram_re(ram_re_z),
        .ram_we(ram_we_z), .ram_rdata(ram_rdata_z), .state_dbg(state_z)
    );

    // ---------------- RAM model ----------------
    logic [7:0] ram [256];
    logic [7:0] init_mem [256];
    logic       ram_load;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_mem[i];
        end else begin
            if (ram_we_a) ram[ram_addr_a] <= ram_wdata_a;
            if (ram_we_z) ram[ram_addr_z] <= ram_wdata_z;
        end
    end
    assign ram_rdata_a = ram[ram_addr_a];
    assign ram_rdata_z = ram[ram_addr_z];

    // ---------------- selected-DUT view ----------------
    bit         sel;
    logic       s_ready, s_err, s_re, s_we;
    logic [7:0] s_rdata, s_addr, s_wdata;

    always_comb begin
        if (sel) begin
            s_ready = bus_z.bus_ready; s_err = bus_z.bus_err; s_rdata = bus_z.rdata;
            s_re = ram_re_z; s_we = ram_we_z; s_addr = ram_addr_z; s_wdata = ram_wdata_z;
        end else begin
            s_ready = bus_a.bus_ready; s_err = bus_a.bus_err; s_rdata = bus_a.rdata;
            s_re = ram_re_a; s_we = ram_we_a; s_addr = ram_addr_a; s_wdata = ram_wdata_a;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata [2];
    bit         exp_err [2];
    bit         buf_v [2];
    logic [7:0] buf_a [2];
    logic [7:0] buf_d [2];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int idx);
        return (idx == 1) ? WS_Z : WS_A;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_rdata[i] = 8'h00; exp_err[i] = 1'b0; buf_v[i] = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        bus_a.req_rd = sel ? 1'b0 : rd;  bus_a.req_wr = sel ? 1'b0 : wr;
        bus_a.req_addr = addr;           bus_a.req_wdata = wdata;
        bus_z.req_rd = sel ? rd : 1'b0;  bus_z.req_wr = sel ? wr : 1'b0;
        bus_z.req_addr = addr;           bus_z.req_wdata = wdata;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        check("wait_ready", s_ready, 1'b1);
    endtask

    // One complete transaction on the selected DUT, checked against the model.
    task automatic do_req(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        int idx, exp_lat, lat, re_n, we_n;
        bit hit, bus_ok;
        idx = sel ? 1 : 0;
        hit = RDBUF_EN && rd && !wr && buf_v[idx] && (buf_a[idx] == addr);
        exp_lat = hit ? 1 : ws_of(idx) + 1;
        drive(rd, wr, addr, wdata);
        step();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        check("accept_busy", s_ready, 1'b0);
        lat = 0; re_n = 0; we_n = 0; bus_ok = 1'b1;
        while (!s_ready && lat < 20) begin
            if (s_re) re_n++;
            if (s_we) we_n++;
            if ((s_re || s_we) && (s_addr !== addr)) bus_ok = 1'b0;
            if (s_we && (s_wdata !== wdata)) bus_ok = 1'b0;
            step();
            lat++;
        end
        if (wr) begin
            ref_mem[addr] = wdata;
            if (buf_a[idx] == addr) buf_v[idx] = 1'b0;
        end else if (hit) begin
            exp_rdata[idx] = buf_d[idx];
        end else begin
            exp_rdata[idx] = ref_mem[addr];
            buf_v[idx] = 1'b1; buf_a[idx] = addr; buf_d[idx] = ref_mem[addr];
        end
        exp_err[idx] = rd && wr;
        check("latency", lat, exp_lat);
        check("re_cycles", re_n, (wr || hit) ? 0 : exp_lat);
        check("we_cycles", we_n, wr ? exp_lat : 0);
        check("ram_addr_data", bus_ok, 1'b1);
        check("strobes_off", {s_re, s_we}, 2'b00);
        check("rdata", s_rdata, exp_rdata[idx]);
        check("bus_err", s_err, exp_err[idx]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sel = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
        init_mem[8'h10] = 8'hA5;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_mem[i];
        model_reset();

        reset_cycle = 1'b1;
        ram_load = 1'b1;
        step();
        step();
        ram_load = 1'b0;
        reset_cycle = 1'b0;

        // reset state
        check("rst_ready", s_ready, 1'b1);
        check("rst_rdata", s_rdata, 8'h00);
        check("rst_err", s_err, 1'b0);
        check("rst_re", s_re, 1'b0);
        check("rst_we", s_we, 1'b0);
        check("rst_addr", s_addr, 8'h00);
        check("rst_wdata", s_wdata, 8'h00);
        check("rst_state", state_a, ST_IDLE);
        check("rst_ready_z", bus_z.bus_ready, 1'b1);

        // read 0x10 with 2 wait states
        do_req(1'b1, 1'b0, 8'h10, 8'h00);
        check("read_a5", s_rdata, 8'hA5);

        // zero-wait-state instance: read then write 0x3C to 0x20, rdata kept
        sel = 1'b1;
        do_req(1'b1, 1'b0, 8'h11, 8'h00);
        do_req(1'b0, 1'b1, 8'h20, 8'h3C);
        do_req(1'b1, 1'b0, 8'h20, 8'h00);
        check("readback_3c", s_rdata, 8'h3C);

        // simultaneous read+write: write performed, error flag, cleared by clean read
        sel = 1'b0;
        do_req(1'b1, 1'b1, 8'h05, 8'h6B);
        check("both_err", s_err, 1'b1);
        do_req(1'b1, 1'b0, 8'h05, 8'h00);
        check("both_wrote", s_rdata, 8'h6B);
        check("err_cleared", s_err, 1'b0);

        // reset during the second ACCESS cycle of a read
        do_req(1'b1, 1'b0, 8'h10, 8'h00);
        drive(1'b1, 1'b0, 8'h07, 8'h00);
        step();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("mid_re", s_re, 1'b1);
        reset_cycle = 1'b1;
        step();
        reset_cycle = 1'b0;
        model_reset();
        check("mid_rst_ready", s_ready, 1'b1);
        check("mid_rst_re", s_re, 1'b0);
        check("mid_rst_rdata", s_rdata, 8'h00);
        check("mid_rst_state", state_a, ST_IDLE);

        // request held through ACCESS: ignored, then accepted one edge after ready
        drive(1'b0, 1'b1, 8'h33, 8'h77);
        for (int k = 0; k <= WS_A; k++) begin
            step();
            check("held_we", s_we, 1'b1);
            check("held_busy", s_ready, 1'b0);
        end
        step();
        check("held_gap_ready", s_ready, 1'b1);
        check("held_gap_we", s_we, 1'b0);
        step();
        check("held_again_busy", s_ready, 1'b0);
        check("held_again_we", s_we, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        wait_ready();
        ref_mem[8'h33] = 8'h77;
        do_req(1'b1, 1'b0, 8'h33, 8'h00);
        check("held_data", s_rdata, 8'h77);

        // repeated reads, write to same address, read again
        do_req(1'b1, 1'b0, 8'h40, 8'h00);
        do_req(1'b1, 1'b0, 8'h40, 8'h00);
        do_req(1'b0, 1'b1, 8'h40, 8'h5A);
        do_req(1'b1, 1'b0, 8'h40, 8'h00);
        check("new_data_40", s_rdata, 8'h5A);

        // randomized traffic over a small address window on both instances
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [7:0] a, d;
            sel  = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            a    = 8'h40 + 8'($urandom_range(0, 3));
            d    = 8'($urandom);
            if (kind == 0)      do_req(1'b1, 1'b1, a, d);
            else if (kind < 4)  do_req(1'b0, 1'b1, a, d);
            else                do_req(1'b1, 1'b0, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
